// File: rtl/ser_par_link_ctrl_if.sv
// Byte-domain link interface between the deserializer side and the
// link-bring-up controller. The controller takes the slave view; the
// byte source/consumer (deserializer and downstream logic) takes the master view.
interface ser_par_link_ctrl_if;
    logic [7:0] data_in;
    logic       byte_vld;
    logic       active;
    logic       valid_out;
    logic [7:0] data_out;
    logic [1:0] state;

    modport master (
        output data_in,
        output byte_vld,
        input  active,
        input  valid_out,
        input  data_out,
        input  state
    );

    modport slave (
        input  data_in,
        input  byte_vld,
        output active,
        output valid_out,
        output data_out,
        output state
    );
endinterface

// File: rtl/ser_par_link_ctrl.sv
// Link-bring-up and data-qualification controller (clk_4f byte domain).
// Hunts for LOCK_COUNT consecutive COMMA bytes, then declares the link active
// and forwards non-COMMA bytes as payload while treating COMMA as idle fill.
// Optional loss-of-lock detection is compiled in by SER_PAR_LINK_CTRL_LOL_EN:
// LOL_COUNT consecutive empty byte slots drop the link back to SEARCH.
//
// state  | meaning
// SEARCH | counting consecutive COMMAs, outputs quiet
// ACTIVE | locked, non-COMMA bytes forwarded as payload
module ser_par_link_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOL_COUNT  = 4
) (
    input logic                clk_4f,
    input logic                reset,
    ser_par_link_ctrl_if.slave link
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACTIVE = 2'd1
    } state_t;

    // Counters are 3 bits wide, so both thresholds must stay within 1..7.
    generate
        if (LOCK_COUNT < 1 || LOCK_COUNT > 7 || LOL_COUNT < 1 || LOL_COUNT > 7) begin : g_bad_param
            $error("ser_par_link_ctrl: LOCK_COUNT and LOL_COUNT must be in 1..7");
        end
    endgenerate

    // Lock happens on the COMMA seen while the run count sits one short.
    localparam logic [2:0] LOCK_LAST = 3'(LOCK_COUNT - 1);

    state_t     state_q;
    logic [2:0] bc_cnt;
    logic       active_q;
    logic       valid_q;
    logic [7:0] data_q;
    logic       is_comma;

`ifdef SER_PAR_LINK_CTRL_LOL_EN
    localparam logic [2:0] LOL_LAST = 3'(LOL_COUNT - 1);
    logic [2:0] lol_cnt;
`endif

    assign is_comma = (link.data_in == COMMA);

    // Lock FSM with registered active/valid/data outputs; reset wins over everything.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q  <= SEARCH;
            bc_cnt   <= '0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
`ifdef SER_PAR_LINK_CTRL_LOL_EN
            lol_cnt  <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    active_q <= 1'b0;
                    if (link.byte_vld) begin
                        if (is_comma) begin
                            if (bc_cnt == LOCK_LAST) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                                bc_cnt   <= '0;
                            end else begin
                                bc_cnt <= bc_cnt + 3'd1;
                            end
                        end else begin
                            bc_cnt <= '0;
                        end
                    end
`ifdef SER_PAR_LINK_CTRL_LOL_EN
                    lol_cnt <= '0;
`endif
                end
                ACTIVE: begin
                    active_q <= 1'b1;
                    if (link.byte_vld) begin
                        if (!is_comma) begin
                            valid_q <= 1'b1;
                            data_q  <= link.data_in;
                        end
`ifdef SER_PAR_LINK_CTRL_LOL_EN
                        lol_cnt <= '0;
`endif
                    end
`ifdef SER_PAR_LINK_CTRL_LOL_EN
                    else if (lol_cnt == LOL_LAST) begin
                        // Too many empty slots: drop lock and demand a fresh COMMA run.
                        state_q  <= SEARCH;
                        active_q <= 1'b0;
                        bc_cnt   <= '0;
                        lol_cnt  <= '0;
                    end else begin
                        lol_cnt <= lol_cnt + 3'd1;
                    end
`endif
                end
                default: begin
                    state_q  <= SEARCH;
                    active_q <= 1'b0;
                    bc_cnt   <= '0;
                end
            endcase
        end
    end

    assign link.active    = active_q;
    assign link.valid_out = valid_q;
    assign link.data_out  = data_q;
    assign link.state     = state_q;
endmodule

// File: tb/tb_ser_par_link_ctrl.sv
// Bench for ser_par_link_ctrl: directed vector table on the default-parameter
// instance, hand sequences for loss-of-lock and LOCK_COUNT sweep, then random
// traffic on three instances against a count-based reference model.
module tb_ser_par_link_ctrl;
    localparam logic [7:0] BC = 8'hBC;
    localparam int LOL_N = 4;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic       vld    = 1'b0;
    logic [7:0] din    = 8'h00;

    int checks   = 0;
    int failures = 0;

    always #5 clk_4f = ~clk_4f;

    ser_par_link_ctrl_if if4 ();
    ser_par_link_ctrl_if if1 ();
    ser_par_link_ctrl_if if7 ();

    assign if4.data_in  = din;
    assign if4.byte_vld = vld;
    assign if1.data_in  = din;
    assign if1.byte_vld = vld;
    assign if7.data_in  = din;
    assign if7.byte_vld = vld;

    ser_par_link_ctrl #(.COMMA(BC), .LOCK_COUNT(4), .LOL_COUNT(LOL_N)) dut4 (
        .clk_4f(clk_4f), .reset(reset), .link(if4.slave));
    ser_par_link_ctrl #(.COMMA(BC), .LOCK_COUNT(1), .LOL_COUNT(LOL_N)) dut1 (
        .clk_4f(clk_4f), .reset(reset), .link(if1.slave));
    ser_par_link_ctrl #(.COMMA(BC), .LOCK_COUNT(7), .LOL_COUNT(LOL_N)) dut7 (
        .clk_4f(clk_4f), .reset(reset), .link(if7.slave));

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] d;
        logic       e_act;
        logic       e_vo;
        logic [7:0] e_do;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        bit         locked;
        int         run;
        int         gap;
        logic       valid;
        logic [7:0] data;
    } mdl_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic a, input logic vo, input logic [7:0] dout);
        vec_t x;
        x.rst = r; x.vld = v; x.d = d; x.e_act = a; x.e_vo = vo; x.e_do = dout;
        vecs.push_back(x);
    endtask

    // Drive one byte slot and move to just after the sampling edge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        reset = r; vld = v; din = d;
        @(posedge clk_4f);
        #1;
    endtask

    // Behavioural reference: lock after `lock` consecutive commas, gaps ignored
    // while searching; payload is any non-comma byte while locked.
    function automatic mdl_t mstep(input mdl_t m, input int lock, input bit r,
                                   input bit v, input logic [7:0] d);
        mdl_t n;
        n = m;
        if (r) begin
            n.locked = 0; n.run = 0; n.gap = 0; n.valid = 0; n.data = 8'h00;
            return n;
        end
        n.valid = 0;
        if (!m.locked) begin
            if (v) begin
                if (d == BC) begin
                    n.run = m.run + 1;
                    if (n.run >= lock) begin
                        n.locked = 1; n.run = 0; n.gap = 0;
                    end
                end else begin
                    n.run = 0;
                end
            end
        end else if (v) begin
            n.gap = 0;
            if (d != BC) begin
                n.valid = 1; n.data = d;
            end
        end else begin
`ifdef SER_PAR_LINK_CTRL_LOL_EN
            n.gap = m.gap + 1;
            if (n.gap >= LOL_N) begin
                n.locked = 0; n.run = 0; n.gap = 0;
            end
`endif
        end
        return n;
    endfunction

    task automatic chk_dut(input string tag, input logic a, input logic vo, input logic [7:0] dout,
                           input logic [1:0] st, input mdl_t m);
        chk({tag, ".active"}, {31'd0, a}, {31'd0, m.locked});
        chk({tag, ".valid_out"}, {31'd0, vo}, {31'd0, m.valid});
        chk({tag, ".data_out"}, {24'd0, dout}, {24'd0, m.data});
        chk({tag, ".state"}, {30'd0, st}, {31'd0, m.locked});
        if (vo) chk({tag, ".valid_implies_active"}, {31'd0, a}, 32'd1);
    endtask

    initial begin
        mdl_t m4, m1, m7;

        // Basic lock and data
        for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 1, 8'h00, 0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    1, 0, 8'h00);
        add(0, 1, 8'hFF, 1, 1, 8'hFF);
        add(0, 1, 8'hEE, 1, 1, 8'hEE);
        add(0, 1, BC,    1, 0, 8'hEE);
        // Broken run
        add(1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, 8'h5A, 0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    1, 0, 8'h00);
        // Gap tolerance
        add(1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 0, 8'h77, 0, 0, 8'h00);
        add(0, 0, BC,    0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 0, 8'h00);
        add(0, 1, BC,    0, 0, 8'h00);
        add(0, 1, BC,    1, 0, 8'h00);
        // Reset mid-operation
        add(1, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) add(0, 1, BC, 0, 0, 8'h00);
        add(0, 1, BC,    1, 0, 8'h00);
        add(0, 1, 8'h11, 1, 1, 8'h11);
        add(0, 1, 8'h22, 1, 1, 8'h22);
        add(1, 1, 8'h33, 0, 0, 8'h00);
        add(0, 1, 8'h44, 0, 0, 8'h00);
        add(0, 1, 8'h55, 0, 0, 8'h00);
        add(0, 1, 8'h66, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].vld, vecs[i].d);
            chk($sformatf("vec%0d.active", i), {31'd0, if4.active}, {31'd0, vecs[i].e_act});
            chk($sformatf("vec%0d.valid_out", i), {31'd0, if4.valid_out}, {31'd0, vecs[i].e_vo});
            chk($sformatf("vec%0d.data_out", i), {24'd0, if4.data_out}, {24'd0, vecs[i].e_do});
            chk($sformatf("vec%0d.state", i), {30'd0, if4.state}, {31'd0, vecs[i].e_act});
        end

        // Loss of lock / gap behaviour while ACTIVE
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 1, BC);
        chk("lol.locked", {31'd0, if4.active}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00);
        chk("lol.gap3_keeps_active", {31'd0, if4.active}, 32'd1);
        cyc(0, 1, BC);
`ifdef SER_PAR_LINK_CTRL_LOL_EN
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00);
        chk("lol.gap3_after_clear", {31'd0, if4.active}, 32'd1);
        cyc(0, 0, 8'h00);
        chk("lol.drop_active", {31'd0, if4.active}, 32'd0);
        chk("lol.drop_valid", {31'd0, if4.valid_out}, 32'd0);
        chk("lol.drop_state", {30'd0, if4.state}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, BC);
        chk("lol.relock_3bc", {31'd0, if4.active}, 32'd0);
        cyc(0, 1, BC);
        chk("lol.relock_4bc", {31'd0, if4.active}, 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 8'h00);
            chk($sformatf("nolol.gap%0d", i + 1), {31'd0, if4.active}, 32'd1);
        end
`endif

        // LOCK_COUNT sweep: 1 and 7
        cyc(1, 0, 8'h00);
        cyc(0, 1, BC);
        chk("sweep1.first_bc", {31'd0, if1.active}, 32'd1);
        chk("sweep7.bc1", {31'd0, if7.active}, 32'd0);
        for (int i = 2; i <= 6; i++) begin
            cyc(0, 1, BC);
            chk($sformatf("sweep7.bc%0d", i), {31'd0, if7.active}, 32'd0);
        end
        cyc(0, 1, BC);
        chk("sweep7.bc7", {31'd0, if7.active}, 32'd1);
        cyc(0, 1, 8'h3C);
        chk("sweep1.payload_valid", {31'd0, if1.valid_out}, 32'd1);
        chk("sweep1.payload_data", {24'd0, if1.data_out}, 32'h3C);

        // Random traffic against the reference model
        m4 = mstep(m4, 4, 1, 0, 8'h00);
        m1 = mstep(m1, 1, 1, 0, 8'h00);
        m7 = mstep(m7, 7, 1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            bit r, v;
            logic [7:0] d;
            int mode;
            mode = (n / 200) % 3;
            r = ($urandom_range(0, 199) == 0);
            v = (mode == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) < 8);
            d = ($urandom_range(0, 1) == 0) ? BC : 8'($urandom);
            if (mode == 2 && $urandom_range(0, 3) != 0) d = BC;
            m4 = mstep(m4, 4, r, v, d);
            m1 = mstep(m1, 1, r, v, d);
            m7 = mstep(m7, 7, r, v, d);
            cyc(r, v, d);
            chk_dut("rnd4", if4.active, if4.valid_out, if4.data_out, if4.state, m4);
            chk_dut("rnd1", if1.active, if1.valid_out, if1.data_out, if1.state, m1);
            chk_dut("rnd7", if7.active, if7.valid_out, if7.data_out, if7.state, m7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ser_par_link_ctrl.md
# ser_par_link_ctrl

- Link-bring-up and data-qualification controller behind the serial-to-parallel deserializer, running in the `clk_4f` byte domain.
- Consumes the deserializer's byte stream and searches for a run of consecutive COMMA (0xBC) characters.
- Declares the link `active` once the run is long enough, then forwards non-COMMA bytes as valid data and treats COMMA bytes as idle fill.
- Drives the `active`/`valid_out` pair that downstream parallel logic consumes.

## Interface
- `COMMA`, 8'hBC: synchronization/idle character.
- `LOCK_COUNT`, 4: consecutive COMMAs required to enter ACTIVE; legal range 1..7.
- `LOL_COUNT`, 4: consecutive invalid byte slots that drop ACTIVE (only with the macro); legal range 1..7.
- `clk_4f` in 1: byte clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in 8: deserialized byte, sampled only when `byte_vld`=1.
- `byte_vld` in 1: deserializer presents a complete byte this cycle.
- `active` out 1: link locked; registered.
- `valid_out` out 1: `data_out` carries a payload byte this cycle; registered.
- `data_out` out 8: payload byte; registered.
- `state` out 2: current FSM state, for debug. SEARCH=2'd0, ACTIVE=2'd1.

## Operation
**Internal state**
- FSM with states SEARCH and ACTIVE.
- 3-bit `bc_cnt` counter; 3-bit `lol_cnt` counter.

**SEARCH**
- `active`=0, `valid_out`=0.
- `byte_vld`=1 and `data_in`==COMMA: `bc_cnt`+1.
- `byte_vld`=1 and any other byte: `bc_cnt`=0.
- `byte_vld`=0: `bc_cnt` holds.
- When a COMMA arrives with `bc_cnt`==LOCK_COUNT-1: go to ACTIVE, clear `bc_cnt`.

**ACTIVE**
- `active`=1.
- `byte_vld`=1 and `data_in`!=COMMA: `valid_out`=1, `data_out`=`data_in`.
- `byte_vld`=1 and `data_in`==COMMA: idle; `valid_out`=0, `data_out` holds.
- `byte_vld`=0: `valid_out`=0, `data_out` holds.
- Without the macro, ACTIVE exits only on `reset`.

**Counters and invariants**
- Counters saturate and never wrap: `bc_cnt` stops at LOCK_COUNT-1 before the transition.
- `valid_out`=1 implies `active`=1 in the same cycle.

**Simultaneous events**
- `reset` dominates every input in the same cycle.

## Timing
- **Reset values** (all registered outputs, at the first edge with `reset`=1): `active`=0, `valid_out`=0, `data_out`=8'h00, `state`=SEARCH, counters 0.
- **Reset mid-stream:** ACTIVE goes to SEARCH at the next edge; `valid_out` falls at that same edge; no partial lock is retained.
- **Lock latency:** `active` rises at the same edge that samples the LOCK_COUNT-th consecutive COMMA.
- **Post-lock data:** a non-COMMA byte sampled on the very next edge already produces `valid_out`=1 at that edge.
- **Data latency:** 1 `clk_4f` cycle from sampling edge to `data_out`/`valid_out`.
- **Back-to-back:** payload bytes stream one per cycle with no bubbles.
- **Idle handling:** a COMMA after payload clears `valid_out` at its sampling edge.
- **No backpressure:** downstream must accept every `valid_out` cycle.

## Configuration
- **`SER_PAR_LINK_CTRL_LOL_EN` defined:** loss-of-lock detection is compiled in.
  - In ACTIVE, each edge with `byte_vld`=0 increments `lol_cnt`; any `byte_vld`=1 clears it.
  - On reaching LOL_COUNT: return to SEARCH, `active`=0 and `valid_out`=0 at that edge, `bc_cnt`=0.
  - A fresh run of LOCK_COUNT COMMAs is then required to relock.
- **Not defined:** `lol_cnt` logic is absent and ACTIVE is left only via `reset`.

## Test plan
- **Basic lock and data:** reset 3 cycles, then bytes 00, BC, BC, BC, BC, FF, EE, BC (all `byte_vld`=1).
  - `active` rises on the 4th BC edge.
  - `valid_out`=1 with `data_out`=FF, then with EE.
  - On the final BC: `valid_out`=0, `data_out` holds EE, `active` stays 1.
- **Broken run:** BC, BC, BC, 5A, BC, BC, BC → `active` stays 0 (`bc_cnt` restarted by 5A). One more BC → `active`=1.
- **Gap tolerance:** BC, BC, `byte_vld`=0 for 3 cycles, BC, BC → `active`=1; gaps do not reset `bc_cnt`.
- **Reset mid-operation:** lock, stream 11, 22, assert `reset` during 33.
  - All outputs reach their reset values at that edge.
  - Payload after reset without COMMAs → `valid_out` stays 0.
- **Loss of lock** (`SER_PAR_LINK_CTRL_LOL_EN` defined): lock, then `byte_vld`=0 for 4 cycles.
  - `active` falls on the 4th edge.
  - A 3-cycle gap leaves `active`=1.
  - Without the macro, a 20-cycle gap leaves `active`=1.
- **Parameter sweep:** LOCK_COUNT=1 → the first BC asserts `active`. LOCK_COUNT=7 → 6 BCs leave `active`=0 and the 7th sets it.
